// File: rtl/atm_pkg.sv
// Shared key codes, debounce state encoding and datapath widths for the ATM keypad front-end.
package atm_pkg;

    localparam int unsigned TECLA_W = 4;
    localparam int unsigned MONTO_W = 32;

    localparam logic [TECLA_W-1:0] TECLA_ACEPTAR = 4'hA;
    localparam logic [TECLA_W-1:0] TECLA_BORRAR  = 4'hB;

    typedef enum logic [1:0] {
        REPOSO       = 2'd0,
        CONFIRMA_ON  = 2'd1,
        PRESIONADA   = 2'd2,
        CONFIRMA_OFF = 2'd3
    } rebote_t;

    function automatic logic es_digito(input logic [TECLA_W-1:0] t);
        return t <= 4'd9;
    endfunction

    // acc*10 + d without a multiplier
    function automatic logic [MONTO_W-1:0] por_diez_mas(input logic [MONTO_W-1:0] acc,
                                                        input logic [TECLA_W-1:0] d);
        return (acc << 3) + (acc << 1) + MONTO_W'(d);
    endfunction

endpackage

// File: rtl/atm_antirrebote.sv
// Two-flop synchronizer plus debounce FSM; emits one evento pulse per accepted press.
module atm_antirrebote
    import atm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CICLOS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [TECLA_W-1:0] tecla_raw,
    input  logic               valida_raw,
    output logic               evento,
    output logic [TECLA_W-1:0] codigo
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CNT_W-1:0] CNT_UNO    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(DEBOUNCE_CICLOS - 1);

    logic               valida_s1, valida_s2;
    logic [TECLA_W-1:0] tecla_s1, tecla_s2;

    rebote_t            state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               evento_d;
    logic [TECLA_W-1:0] codigo_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valida_s1 <= 1'b0;
            valida_s2 <= 1'b0;
            tecla_s1  <= '0;
            tecla_s2  <= '0;
        end else begin
            valida_s1 <= valida_raw;
            valida_s2 <= valida_s1;
            tecla_s1  <= tecla_raw;
            tecla_s2  <= tecla_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= REPOSO;
            cnt    <= '0;
            evento <= 1'b0;
            codigo <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            evento <= evento_d;
            codigo <= codigo_d;
        end
    end

    // The sample that completes the count is the one that fires, so the
    // transition happens while the counter still holds DEBOUNCE_CICLOS-1.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        evento_d = 1'b0;
        codigo_d = codigo;
        case (state)
            REPOSO: begin
                if (valida_s2) begin
                    state_d = CONFIRMA_ON;
                    cnt_d   = CNT_UNO;
                end
            end
            CONFIRMA_ON: begin
                if (!valida_s2) begin
                    state_d = REPOSO;
                end else if (cnt == CNT_ULTIMO) begin
                    state_d  = PRESIONADA;
                    evento_d = 1'b1;
                    codigo_d = tecla_s2;
                end else begin
                    cnt_d = cnt + CNT_UNO;
                end
            end
            PRESIONADA: begin
                if (!valida_s2) begin
                    state_d = CONFIRMA_OFF;
                    cnt_d   = CNT_UNO;
                end
            end
            CONFIRMA_OFF: begin
                if (valida_s2) begin
                    state_d = PRESIONADA;
                end else if (cnt == CNT_ULTIMO) begin
                    state_d = REPOSO;
                end else begin
                    cnt_d = cnt + CNT_UNO;
                end
            end
            default: state_d = REPOSO;
        endcase
    end

endmodule

// File: rtl/atm_teclado.sv
// Keypad front-end: debounced presses become PIN digit strobes or an accumulated binary amount.
module atm_teclado
    import atm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CICLOS = 16,
    parameter int unsigned MAX_DIGITOS     = 9
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [TECLA_W-1:0] TECLA,
    input  logic               TECLA_VALIDA,
    input  logic               HABILITAR,
    input  logic               MODO_MONTO,
    output logic [TECLA_W-1:0] DIGITO,
    output logic               DIGITO_STB,
    output logic [MONTO_W-1:0] MONTO,
    output logic               MONTO_STB,
    output logic               ERROR_TECLA
);

    localparam int unsigned N_W = $clog2(MAX_DIGITOS + 1);
    localparam logic [N_W-1:0] N_MAX = N_W'(MAX_DIGITOS);
    localparam logic [N_W-1:0] N_UNO = N_W'(1);

    logic               evento;
    logic [TECLA_W-1:0] codigo;

    logic [MONTO_W-1:0] acc, acc_d;
    logic [N_W-1:0]     n_dig, n_dig_d;
    logic               modo_q;
    logic [TECLA_W-1:0] digito_d;
    logic [MONTO_W-1:0] monto_d;
    logic               digito_stb_d, monto_stb_d, error_d;

    atm_antirrebote #(
        .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_antirrebote (
        .clk       (Clk),
        .rst       (Reset),
        .tecla_raw (TECLA),
        .valida_raw(TECLA_VALIDA),
        .evento    (evento),
        .codigo    (codigo)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            acc         <= '0;
            n_dig       <= '0;
            modo_q      <= 1'b0;
            DIGITO      <= '0;
            DIGITO_STB  <= 1'b0;
            MONTO       <= '0;
            MONTO_STB   <= 1'b0;
            ERROR_TECLA <= 1'b0;
        end else begin
            acc         <= acc_d;
            n_dig       <= n_dig_d;
            modo_q      <= MODO_MONTO;
            DIGITO      <= digito_d;
            DIGITO_STB  <= digito_stb_d;
            MONTO       <= monto_d;
            MONTO_STB   <= monto_stb_d;
            ERROR_TECLA <= error_d;
        end
    end

    // A mode change clears first; an event in the same cycle then acts on the cleared entry.
    always_comb begin
        acc_d        = acc;
        n_dig_d      = n_dig;
        digito_d     = DIGITO;
        monto_d      = MONTO;
        digito_stb_d = 1'b0;
        monto_stb_d  = 1'b0;
        error_d      = 1'b0;

        if (MODO_MONTO != modo_q) begin
            acc_d   = '0;
            n_dig_d = '0;
        end

        if (!HABILITAR) begin
            acc_d   = '0;
            n_dig_d = '0;
        end else if (evento) begin
            if (!MODO_MONTO) begin
                if (es_digito(codigo)) begin
                    digito_d     = codigo;
                    digito_stb_d = 1'b1;
                end else begin
                    error_d = 1'b1;
                end
            end else if (es_digito(codigo)) begin
                if (n_dig_d < N_MAX) begin
                    acc_d   = por_diez_mas(acc_d, codigo);
                    n_dig_d = n_dig_d + N_UNO;
                end else begin
                    error_d = 1'b1;
                end
            end else if (codigo == TECLA_ACEPTAR) begin
                if (n_dig_d != '0) begin
                    monto_d     = acc_d;
                    monto_stb_d = 1'b1;
                    acc_d       = '0;
                    n_dig_d     = '0;
                end else begin
                    error_d = 1'b1;
                end
            end else if (codigo == TECLA_BORRAR) begin
                acc_d   = '0;
                n_dig_d = '0;
            end else begin
                error_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_atm_teclado.sv
// Scoreboard bench for atm_teclado with DEBOUNCE_CICLOS=4, MAX_DIGITOS=9.
module tb_atm_teclado;

    localparam int unsigned DEB = 4;
    localparam int unsigned MAXD = 9;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  TECLA;
    logic        TECLA_VALIDA;
    logic        HABILITAR;
    logic        MODO_MONTO;
    logic [3:0]  DIGITO;
    logic        DIGITO_STB;
    logic [31:0] MONTO;
    logic        MONTO_STB;
    logic        ERROR_TECLA;

    atm_teclado #(
        .DEBOUNCE_CICLOS(DEB),
        .MAX_DIGITOS    (MAXD)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .TECLA      (TECLA),
        .TECLA_VALIDA(TECLA_VALIDA),
        .HABILITAR  (HABILITAR),
        .MODO_MONTO (MODO_MONTO),
        .DIGITO     (DIGITO),
        .DIGITO_STB (DIGITO_STB),
        .MONTO      (MONTO),
        .MONTO_STB  (MONTO_STB),
        .ERROR_TECLA(ERROR_TECLA)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_stb = 0;
    logic [63:0] sb_q[$];

    // reference model of the amount entry
    logic [31:0] m_acc = '0;
    int          m_n   = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(input logic [1:0] kind, input logic [31:0] val);
        return {30'd0, kind, val};
    endfunction

    always @(negedge Clk) begin
        if (!Reset && (DIGITO_STB || MONTO_STB || ERROR_TECLA)) begin
            logic [63:0] obs;
            check("strobe_excl", 64'($countones({DIGITO_STB, MONTO_STB, ERROR_TECLA})), 64'd1);
            if (DIGITO_STB) begin
                obs   = mk(2'd1, {28'd0, DIGITO});
                t_stb = cyc;
            end else if (MONTO_STB) begin
                obs = mk(2'd2, MONTO);
            end else begin
                obs = mk(2'd3, 32'd0);
            end
            if (sb_q.size() == 0) check("unexpected_evt", obs, 64'd0);
            else check("evt", obs, sb_q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    task automatic expect_key(input logic [3:0] k);
        if (!HABILITAR) return;
        if (!MODO_MONTO) begin
            if (k <= 4'd9) sb_q.push_back(mk(2'd1, {28'd0, k}));
            else sb_q.push_back(mk(2'd3, 32'd0));
        end else if (k <= 4'd9) begin
            if (m_n < int'(MAXD)) begin
                m_acc = m_acc * 32'd10 + 32'(k);
                m_n++;
            end else begin
                sb_q.push_back(mk(2'd3, 32'd0));
            end
        end else if (k == 4'hA) begin
            if (m_n > 0) begin
                sb_q.push_back(mk(2'd2, m_acc));
                m_acc = '0;
                m_n   = 0;
            end else begin
                sb_q.push_back(mk(2'd3, 32'd0));
            end
        end else if (k == 4'hB) begin
            m_acc = '0;
            m_n   = 0;
        end else begin
            sb_q.push_back(mk(2'd3, 32'd0));
        end
    endtask

    task automatic press(input logic [3:0] k);
        expect_key(k);
        TECLA        = k;
        TECLA_VALIDA = 1'b1;
        tick(12);
        TECLA_VALIDA = 1'b0;
        tick(12);
    endtask

    task automatic model_clear();
        m_acc = '0;
        m_n   = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_digito"}, 64'(DIGITO), 64'd0);
        check({tag, "_dstb"}, 64'(DIGITO_STB), 64'd0);
        check({tag, "_monto"}, 64'(MONTO), 64'd0);
        check({tag, "_mstb"}, 64'(MONTO_STB), 64'd0);
        check({tag, "_err"}, 64'(ERROR_TECLA), 64'd0);
    endtask

    initial begin
        int t_rise;
        Reset        = 1'b1;
        TECLA        = 4'd0;
        TECLA_VALIDA = 1'b0;
        HABILITAR    = 1'b0;
        MODO_MONTO   = 1'b0;
        tick(3);
        check_idle_outputs("reset");
        Reset = 1'b0;
        tick(2);
        HABILITAR = 1'b1;
        tick(2);

        // PIN mode digits, then a non-digit that must be rejected
        press(4'd5);
        press(4'd9);
        press(4'd1);
        press(4'd6);
        press(4'hA);
        press(4'hD);

        // bouncy press: three short pulses before a clean hold
        TECLA = 4'd5;
        for (int i = 0; i < 3; i++) begin
            TECLA_VALIDA = 1'b1;
            tick(2);
            TECLA_VALIDA = 1'b0;
            tick(2);
        end
        expect_key(4'd5);
        TECLA_VALIDA = 1'b1;
        t_rise = cyc;
        tick(20);
        TECLA_VALIDA = 1'b0;
        tick(12);
        check("bounce_latency", 64'(t_stb - t_rise), 64'(DEB + 3));

        // amount mode
        MODO_MONTO = 1'b1;
        model_clear();
        tick(4);
        press(4'd1); press(4'd0); press(4'd0); press(4'd0); press(4'd0); press(4'hA);
        press(4'd9); press(4'd0); press(4'd0); press(4'd0); press(4'hA);
        for (int i = 0; i < 10; i++) press(4'd9);
        press(4'hA);
        press(4'hA);
        check("monto_hold", 64'(MONTO), 64'd999999999);
        press(4'd8); press(4'd0); press(4'hB); press(4'd2); press(4'hA);
        press(4'hE);
        press(4'd7); press(4'd7);
        HABILITAR = 1'b0;
        model_clear();
        tick(5);
        HABILITAR = 1'b1;
        tick(2);
        press(4'hA);
        check("monto_after_hab", 64'(MONTO), 64'd2);

        // reset in the middle of an entry with a key held
        press(4'd4);
        press(4'd5);
        TECLA        = 4'd6;
        TECLA_VALIDA = 1'b1;
        tick(10);
        #3 Reset = 1'b1;
        #1 check_idle_outputs("midreset");
        TECLA_VALIDA = 1'b0;
        model_clear();
        tick(3);
        Reset = 1'b0;
        tick(3);
        press(4'd3);
        press(4'hA);
        check("monto_final", 64'(MONTO), 64'd3);

        tick(10);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/atm_teclado.md
Name: atm_teclado

Overview:
Keypad front-end for the ATM controller. Synchronizes and debounces a raw keypad (key code plus press level) and turns each accepted press into a clean event. In PIN mode each press is forwarded as a DIGITO/DIGITO_STB pulse. In amount mode decimal digits are accumulated into a 32-bit binary MONTO and released with a one-cycle MONTO_STB when the enter key is pressed. Sits directly upstream of the ATM controller and drives its DIGITO, DIGITO_STB, MONTO and MONTO_STB inputs.

Parameters:
DEBOUNCE_CICLOS, 16, consecutive stable synchronized samples required to accept a press or a release (minimum 2)
MAX_DIGITOS, 9, maximum digits accumulated per amount (9 keeps 999999999 inside 32 bits)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
TECLA  input  4  raw key code: 0-9 digit, 0xA ACEPTAR (enter), 0xB BORRAR (clear), 0xC-0xF ignored
TECLA_VALIDA  input  1  raw, bouncy key-pressed level, asynchronous to Clk
HABILITAR  input  1  card present; when low, events are discarded and the accumulator is cleared
MODO_MONTO  input  1  0 = PIN mode, 1 = amount mode
DIGITO  output  4  last digit forwarded in PIN mode
DIGITO_STB  output  1  one-cycle pulse, DIGITO valid
MONTO  output  32  binary amount, held until the next accepted ACEPTAR
MONTO_STB  output  1  one-cycle pulse, MONTO valid
ERROR_TECLA  output  1  one-cycle pulse on a rejected press

Behaviour:
- Reset (asynchronous, Reset=1): all outputs 0, accumulator 0, digit count 0, debounce FSM in REPOSO, synchronizers cleared.
- Synchronization: TECLA_VALIDA and TECLA each pass through two flip-flops. Only the synchronized values are used.
- Debounce FSM (states REPOSO, CONFIRMA_ON, PRESIONADA, CONFIRMA_OFF):
  - REPOSO: sync level high -> CONFIRMA_ON with counter=1.
  - CONFIRMA_ON: level high increments the counter; any low sample -> REPOSO. When the counter reaches DEBOUNCE_CICLOS: capture the synchronized TECLA, emit one internal event, go to PRESIONADA.
  - PRESIONADA: level low -> CONFIRMA_OFF with counter=1.
  - CONFIRMA_OFF: level low increments the counter; any high sample -> PRESIONADA. At DEBOUNCE_CICLOS -> REPOSO.
  - Exactly one event per physical press. Holding a key never repeats.
- Latency: the event is registered DEBOUNCE_CICLOS+2 cycles after the raw level rises cleanly. Output strobes assert on the edge after the event.
- Event handling when HABILITAR=0: event dropped, no strobe, no error. Accumulator and count forced to 0 every cycle.
- Event handling in PIN mode (MODO_MONTO=0):
  - digit 0-9: DIGITO<=code, DIGITO_STB=1 for one cycle.
  - ACEPTAR, BORRAR, 0xC-0xF: ERROR_TECLA pulse.
- Event handling in amount mode (MODO_MONTO=1):
  - digit with count<MAX_DIGITOS: acc<=acc*10+digit (32-bit, computed as (acc<<3)+(acc<<1)+digit), count+1.
  - digit with count=MAX_DIGITOS: ignored, ERROR_TECLA pulse.
  - ACEPTAR with count>0: MONTO<=acc and MONTO_STB pulse in the same cycle; acc and count cleared.
  - ACEPTAR with count=0: ERROR_TECLA pulse, MONTO unchanged.
  - BORRAR: acc and count cleared, no strobe.
  - 0xC-0xF: ERROR_TECLA pulse.
- MODO_MONTO transition (either direction): acc and count cleared on the cycle the change is seen.
- Strobes are mutually exclusive and never wider than one cycle. DIGITO and MONTO hold their values between strobes.
- Reset mid-debounce or mid-entry: everything returns to reset values. A key still held after Reset releases is accepted as a new press once debounced.

Decomposition:
- Package atm_pkg: key code constants (TECLA_ACEPTAR=4'hA, TECLA_BORRAR=4'hB), debounce state encoding, MONTO width constant (32).
- Sub-module atm_antirrebote: the 2-FF synchronizer plus debounce FSM. Outputs a one-cycle evento and the captured 4-bit code. The top level holds the mode decode and the accumulator.

Test Plan (DEBOUNCE_CICLOS=4):
- PIN mode, HABILITAR=1, clean presses 5,9,1,6 -> four DIGITO_STB pulses with DIGITO=5,9,1,6; MONTO_STB stays 0.
- Press 5 with 3 bounce toggles shorter than 4 cycles, then held 20 cycles -> exactly one DIGITO_STB, DIGITO=5, at debounce+2 latency after the last bounce.
- Amount mode, keys 1,0,0,0,0 then ACEPTAR -> one MONTO_STB, MONTO=10000. Then keys 9,0,0,0 then ACEPTAR -> MONTO=9000.
- Amount mode, ten 9 keys then ACEPTAR -> ERROR_TECLA on the 10th digit; MONTO=999999999. ACEPTAR alone afterwards -> ERROR_TECLA, MONTO stays 999999999.
- Amount mode, keys 8,0 then BORRAR then 2 then ACEPTAR -> MONTO=2. Keys 7,7 then HABILITAR pulsed low then ACEPTAR -> ERROR_TECLA, no MONTO_STB.
- Reset asserted asynchronously mid-entry (keys 4,5 entered, key held) -> all outputs 0 immediately. After release and re-press of 3 plus ACEPTAR -> MONTO=3.
